sort_in_collector: RTL and testbench

- Upstream feeder for the parallel sorter.
- Accepts a serial stream of SIZE_DATA-bit elements over a valid/ready handshake.
- Packs NUM_ELEM elements into one flat vector and presents it to the sorter through a second valid/ready handshake.
- Holds the frame stable until the sorter takes it, then refills.

---
 rtl/sort_in_collector_pkg.sv | 23 ++
 rtl/sort_in_collector_if.sv | 29 ++
 rtl/sort_in_collector.sv | 92 +++++++++
 tb/tb_sort_in_collector.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sort_in_collector_pkg.sv
// rtl/sort_in_collector_pkg.sv - shared types and helpers for the sorter input collector
package sort_in_collector_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // Widest element the pad helper can produce; callers slice down to SIZE_DATA.
  localparam int PAD_MAX_W = 256;

  function automatic int count_width(input int num_elem);
    return $clog2(num_elem + 1);
  endfunction

  // Pad value sorts to the tail: all-ones for ascending, all-zeros for descending.
  function automatic logic [PAD_MAX_W-1:0] pad_value(input bit is_asc, input int size_data);
    logic [PAD_MAX_W-1:0] ones;
    ones = '1;
    return is_asc ? (ones >> (PAD_MAX_W - size_data)) : '0;
  endfunction

endpackage

// File: rtl/sort_in_collector_if.sv
// rtl/sort_in_collector_if.sv - element-in / frame-out handshake bundle for sort_in_collector
interface sort_in_collector_if #(
  parameter int NUM_ELEM  = 8,
  parameter int SIZE_DATA = 8
);
  import sort_in_collector_pkg::*;

  localparam int CW = count_width(NUM_ELEM);

  logic                          i_valid;
  logic [SIZE_DATA-1:0]          i_data;
  logic                          i_last;
  logic                          o_ready;
  logic                          o_valid;
  logic [NUM_ELEM*SIZE_DATA-1:0] o_data;
  logic [CW-1:0]                 o_count;
  logic                          i_ready;

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_count
  );

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_count
  );

endinterface

// File: rtl/sort_in_collector.sv
// rtl/sort_in_collector.sv - packs NUM_ELEM serial elements into one frame; SORT_COLLECT_PAD_EN enables short padded frames
module sort_in_collector
  import sort_in_collector_pkg::*;
#(
  parameter bit IS_ASC    = 1'b1,
  parameter int NUM_ELEM  = 8,
  parameter int SIZE_DATA = 8
) (
  input logic             i_clk,
  input logic             i_reset,
  sort_in_collector_if.slave bus
);

  localparam int            CW       = count_width(NUM_ELEM);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_ELEM - 1);

  state_t                        state_q, state_d;
  logic [CW-1:0]                 count_q, count_d;
  logic                          valid_q;
  logic [NUM_ELEM*SIZE_DATA-1:0] data_q;
  logic [CW-1:0]                 ocount_q;
  logic                          accept;
  logic                          close;
  logic                          last_flag;

`ifdef SORT_COLLECT_PAD_EN
  localparam logic [PAD_MAX_W-1:0] PAD_FULL = pad_value(IS_ASC, SIZE_DATA);
  localparam logic [SIZE_DATA-1:0] PAD      = PAD_FULL[SIZE_DATA-1:0];
  assign last_flag = bus.i_last;
`else
  wire unused_last = bus.i_last;
  assign last_flag = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    accept  = 1'b0;
    close   = 1'b0;
    case (state_q)
      FILL: begin
        accept = bus.i_valid;
        if (accept) begin
          count_d = count_q + CW'(1);
          if (count_q == LAST_IDX || last_flag) begin
            close   = 1'b1;
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (bus.i_ready) begin
          state_d = FILL;
          count_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q  <= FILL;
      count_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ocount_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= (state_d == FULL);
      if (close) ocount_q <= count_d;
      if (accept) begin
        // Current element lands at slot[count]; a closing short frame pads everything above it.
        for (int k = 0; k < NUM_ELEM; k++) begin
          if (CW'(k) == count_q)
            data_q[k*SIZE_DATA +: SIZE_DATA] <= bus.i_data;
`ifdef SORT_COLLECT_PAD_EN
          else if (last_flag && CW'(k) > count_q)
            data_q[k*SIZE_DATA +: SIZE_DATA] <= PAD;
`endif
        end
      end
    end
  end

  assign bus.o_ready = (state_q == FILL) && i_reset;
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_count = ocount_q;

endmodule

// File: tb/tb_sort_in_collector.sv
// tb/tb_sort_in_collector.sv - directed self-checking bench for sort_in_collector
module tb_sort_in_collector;
  import sort_in_collector_pkg::*;

  localparam int N = 8;
  localparam int W = 8;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       valid = 1'b0;
  logic       last  = 1'b0;
  logic       rdy   = 1'b0;
  logic [7:0] din   = 8'h00;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  sort_in_collector_if #(.NUM_ELEM(N), .SIZE_DATA(W)) bus_a ();
  sort_in_collector_if #(.NUM_ELEM(N), .SIZE_DATA(W)) bus_b ();

  assign bus_a.i_valid = valid;
  assign bus_a.i_data  = din;
  assign bus_a.i_last  = last;
  assign bus_a.i_ready = rdy;
  assign bus_b.i_valid = valid;
  assign bus_b.i_data  = din;
  assign bus_b.i_last  = last;
  assign bus_b.i_ready = rdy;

  sort_in_collector #(.IS_ASC(1'b1), .NUM_ELEM(N), .SIZE_DATA(W)) dut_a (
    .i_clk   (clk),
    .i_reset (rstn),
    .bus     (bus_a)
  );

  sort_in_collector #(.IS_ASC(1'b0), .NUM_ELEM(N), .SIZE_DATA(W)) dut_b (
    .i_clk   (clk),
    .i_reset (rstn),
    .bus     (bus_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    valid = 1'b1;
    din   = d;
    last  = l;
    while (bus_a.o_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $error("FAIL push_timeout observed=o_ready_low expected=o_ready_high");
    end
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  function automatic logic [63:0] ramp(input logic [7:0] b);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = b + 8'(i);
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_o_valid", 64'(bus_a.o_valid), 64'd0);
    chk("rst_o_data",  bus_a.o_data,       64'd0);
    chk("rst_o_count", 64'(bus_a.o_count), 64'd0);
    chk("rst_o_ready", 64'(bus_a.o_ready), 64'd0);
    rstn = 1'b1;
    #1;
    chk("rel_o_ready", 64'(bus_a.o_ready), 64'd1);

    // full frame, sorter always ready
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b0);
    chk("full_o_valid", 64'(bus_a.o_valid), 64'd1);
    chk("full_o_data",  bus_a.o_data,       64'h1716151413121110);
    chk("full_b_data",  bus_b.o_data,       64'h1716151413121110);
    chk("full_o_count", 64'(bus_a.o_count), 64'd8);
    chk("full_o_ready", 64'(bus_a.o_ready), 64'd0);
    tick();
    chk("full_drop_valid", 64'(bus_a.o_valid), 64'd0);
    chk("full_ready_back", 64'(bus_a.o_ready), 64'd1);

    // backpressure with upstream holding 8'hAA
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i), 1'b0);
    chk("bp_o_valid", 64'(bus_a.o_valid), 64'd1);
    valid = 1'b1;
    din   = 8'hAA;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_o_ready", 64'(bus_a.o_ready), 64'd0);
    end
    chk("bp_hold_data",  bus_a.o_data,       ramp(8'h20));
    chk("bp_hold_valid", 64'(bus_a.o_valid), 64'd1);
    rdy = 1'b1;
    tick();
    chk("bp_handoff_valid", 64'(bus_a.o_valid), 64'd0);
    chk("bp_handoff_ready", 64'(bus_a.o_ready), 64'd1);
    rdy = 1'b0;
    tick();
    valid = 1'b0;
    for (int i = 1; i < 8; i++) push(8'h30 + 8'(i), 1'b0);
    chk("bp_next_data",  bus_a.o_data,       64'h37363534333231AA);
    chk("bp_next_count", 64'(bus_a.o_count), 64'd8);
    rdy = 1'b1;
    tick();
    chk("bp_next_drop", 64'(bus_a.o_valid), 64'd0);

    // short frame: i_last on the third element
    rdy = 1'b0;
    push(8'h05, 1'b0);
    push(8'h03, 1'b0);
    push(8'h09, 1'b1);
`ifdef SORT_COLLECT_PAD_EN
    chk("pad_o_valid", 64'(bus_a.o_valid), 64'd1);
    chk("pad_o_count", 64'(bus_a.o_count), 64'd3);
    chk("pad_asc_data",  bus_a.o_data, 64'hFFFFFFFFFF090305);
    chk("pad_desc_data", bus_b.o_data, 64'h0000000000090305);
    chk("pad_o_ready", 64'(bus_a.o_ready), 64'd0);
`else
    chk("nopad_no_early", 64'(bus_a.o_valid), 64'd0);
    push(8'h0A, 1'b0);
    push(8'h0B, 1'b0);
    push(8'h0C, 1'b0);
    push(8'h0D, 1'b0);
    chk("nopad_still_fill", 64'(bus_a.o_valid), 64'd0);
    push(8'h0E, 1'b0);
    chk("nopad_o_valid", 64'(bus_a.o_valid), 64'd1);
    chk("nopad_o_data",  bus_a.o_data,       64'h0E0D0C0B0A090305);
    chk("nopad_o_count", 64'(bus_a.o_count), 64'd8);
`endif
    rdy = 1'b1;
    tick();
    chk("short_drop", 64'(bus_a.o_valid), 64'd0);

    // reset in the middle of a fill
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h41 + 8'(i), 1'b0);
    rstn = 1'b0;
    tick();
    chk("mid_rst_o_ready", 64'(bus_a.o_ready), 64'd0);
    chk("mid_rst_o_valid", 64'(bus_a.o_valid), 64'd0);
    chk("mid_rst_o_data",  bus_a.o_data,       64'd0);
    chk("mid_rst_o_count", 64'(bus_a.o_count), 64'd0);
    rstn = 1'b1;
    #1;
    for (int i = 0; i < 7; i++) push(8'h50 + 8'(i), 1'b0);
    chk("post_rst_no_early", 64'(bus_a.o_valid), 64'd0);
    push(8'h57, 1'b0);
    chk("post_rst_o_valid", 64'(bus_a.o_valid), 64'd1);
    chk("post_rst_o_data",  bus_a.o_data,       ramp(8'h50));
    chk("post_rst_o_count", 64'(bus_a.o_count), 64'd8);
    rdy = 1'b1;
    tick();
    chk("post_rst_drop", 64'(bus_a.o_valid), 64'd0);

    // gapped input across three back-to-back frames
    rdy = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        push(8'h60 + 8'(f * 16) + 8'(i), 1'b0);
      end
      chk("gap_o_valid", 64'(bus_a.o_valid), 64'd1);
      chk("gap_o_data",  bus_a.o_data,       ramp(8'h60 + 8'(f * 16)));
      chk("gap_b_data",  bus_b.o_data,       ramp(8'h60 + 8'(f * 16)));
      chk("gap_o_count", 64'(bus_a.o_count), 64'd8);
      tick();
      chk("gap_one_cycle", 64'(bus_a.o_valid), 64'd0);
      chk("gap_ready",     64'(bus_a.o_ready), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
